// File: rtl/ttt_turn_scheduler_if.sv
// Move-request handshake and board feedback shared by the two requesters,
// the position registers and the turn scheduler.
interface ttt_turn_scheduler_if;
   logic       pl_req;
   logic [3:0] pl_pos;
   logic       pc_req;
   logic [3:0] pc_pos;
   logic [8:0] occupied;
   logic       win;
   logic [1:0] who;
   logic       no_space;
   logic       pl_ack;
   logic       pl_nack;
   logic       pc_ack;
   logic       pc_nack;
   logic [8:0] pl_en;
   logic [8:0] pc_en;

   modport master (
      output pl_req, pl_pos, pc_req, pc_pos, occupied, win, who, no_space,
      input  pl_ack, pl_nack, pc_ack, pc_nack, pl_en, pc_en
   );

   modport slave (
      input  pl_req, pl_pos, pc_req, pc_pos, occupied, win, who, no_space,
      output pl_ack, pl_nack, pc_ack, pc_nack, pl_en, pc_en
   );
endinterface

// File: rtl/ttt_turn_scheduler.sv
// Sequences one tic-tac-toe game: alternates player/computer moves, rejects bad
// squares, pulses one-hot board write enables and ends on win, draw or timeout.
module ttt_turn_scheduler #(
   parameter bit FIRST_MOVER = 1'b0,
   parameter int TIMEOUT     = 1000,
   parameter int TW          = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   ttt_turn_scheduler_if.slave  bus,
   output logic                 turn,
   output logic                 busy,
   output logic                 game_over,
   output logic [1:0]           result,
   output logic                 forfeit,
   output logic [3:0]           move_count
);
   typedef enum logic [2:0] {IDLE, WAIT_MOVE, COMMIT, CHECK, DONE} state_t;

   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

   state_t        state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          turn_nx, busy_nx, game_over_nx, forfeit_nx;
   logic [1:0]    result_nx;
   logic [3:0]    move_count_nx;
   logic          pl_ack_nx, pl_nack_nx, pc_ack_nx, pc_nack_nx;
   logic [8:0]    pl_en_nx, pc_en_nx, one_hot;

   logic          on_req, sampled, accept, reject, expire;
   logic [3:0]    on_pos;
   logic [15:0]   blocked;

   // Only the on-turn requester is looked at; squares 9..15 read as occupied.
   // The cycle a nack is showing is skipped so a held request is not nacked twice.
   always_comb begin
      on_req  = turn ? bus.pc_req : bus.pl_req;
      on_pos  = turn ? bus.pc_pos : bus.pl_pos;
      blocked = {7'h7f, bus.occupied};
      sampled = on_req && !(bus.pl_nack || bus.pc_nack);
      accept  = sampled && !blocked[on_pos];
      reject  = sampled && blocked[on_pos];
      expire  = (TIMEOUT != 0) && (timer == LAST_TICK);
      one_hot = 9'd1 << on_pos;
   end

   // NOTE: sequential state uses non-blocking assignments only, and the
   // asynchronous reset clears every output register including the enables.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         turn        <= FIRST_MOVER;
         busy        <= 1'b0;
         game_over   <= 1'b0;
         result      <= 2'b00;
         forfeit     <= 1'b0;
         move_count  <= 4'd0;
         bus.pl_ack  <= 1'b0;
         bus.pl_nack <= 1'b0;
         bus.pc_ack  <= 1'b0;
         bus.pc_nack <= 1'b0;
         bus.pl_en   <= 9'd0;
         bus.pc_en   <= 9'd0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         turn        <= turn_nx;
         busy        <= busy_nx;
         game_over   <= game_over_nx;
         result      <= result_nx;
         forfeit     <= forfeit_nx;
         move_count  <= move_count_nx;
         bus.pl_ack  <= pl_ack_nx;
         bus.pl_nack <= pl_nack_nx;
         bus.pc_ack  <= pc_ack_nx;
         bus.pc_nack <= pc_nack_nx;
         bus.pl_en   <= pl_en_nx;
         bus.pc_en   <= pc_en_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start) state_nx = WAIT_MOVE;
         WAIT_MOVE: if (accept) state_nx = COMMIT;
                    else if (expire) state_nx = DONE;
         COMMIT:    state_nx = CHECK;
         CHECK:     state_nx = (bus.win || bus.no_space) ? DONE : WAIT_MOVE;
         default:   state_nx = state;
      endcase
   end

   always_comb begin
      // NOTE: every *_nx gets a default first, so no branch can infer a latch.
      timer_nx      = timer;
      turn_nx       = turn;
      result_nx     = result;
      forfeit_nx    = forfeit;
      move_count_nx = move_count;
      pl_ack_nx     = 1'b0;
      pl_nack_nx    = 1'b0;
      pc_ack_nx     = 1'b0;
      pc_nack_nx    = 1'b0;
      pl_en_nx      = 9'd0;
      pc_en_nx      = 9'd0;
      case (state)
         IDLE: if (start) begin
            timer_nx      = '0;
            turn_nx       = FIRST_MOVER;
            result_nx     = 2'b00;
            forfeit_nx    = 1'b0;
            move_count_nx = 4'd0;
         end
         WAIT_MOVE: begin
            timer_nx = timer + TW'(1);
            if (accept) begin
               move_count_nx = move_count + 4'd1;
               if (turn) begin
                  pc_ack_nx = 1'b1;
                  pc_en_nx  = one_hot;
               end else begin
                  pl_ack_nx = 1'b1;
                  pl_en_nx  = one_hot;
               end
            end else begin
               if (reject) begin
                  pc_nack_nx = turn;
                  pl_nack_nx = !turn;
               end
               // The stalling side forfeits, so the other side is the winner.
               if (expire) begin
                  forfeit_nx = 1'b1;
                  result_nx  = turn ? 2'b01 : 2'b10;
               end
            end
         end
         CHECK: begin
            if (bus.win)           result_nx = bus.who;
            else if (bus.no_space) result_nx = 2'b11;
            else begin
               turn_nx  = !turn;
               timer_nx = '0;
            end
         end
         default: ;
      endcase
      busy_nx      = (state_nx == WAIT_MOVE) || (state_nx == COMMIT) || (state_nx == CHECK);
      game_over_nx = (state_nx == DONE);
   end
endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Self-checking bench: an external board model feeds occupied/win/no_space while a
// game-level model predicts handshakes, turns, results and timeouts cycle by cycle.
module tb_ttt_turn_scheduler;
   localparam int TIMEOUT = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       turn, busy, game_over, forfeit;
   logic [1:0] result;
   logic [3:0] move_count;

   ttt_turn_scheduler_if bus ();

   ttt_turn_scheduler #(.FIRST_MOVER(1'b0), .TIMEOUT(TIMEOUT), .TW(10)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .bus        (bus.slave),
      .turn       (turn),
      .busy       (busy),
      .game_over  (game_over),
      .result     (result),
      .forfeit    (forfeit),
      .move_count (move_count)
   );

   always #5 clock = ~clock;

   int nrun  = 0;
   int nfail = 0;

   // Model of the game: 0 empty, 1 player, 2 computer.
   logic [1:0] mboard [9];
   bit         mturn, mdone, mforfeit;
   logic [1:0] mresult;
   int         mcount, k;

   function automatic logic [1:0] line_winner(input logic [1:0] b [9]);
      int l [8][3];
      logic [1:0] w;
      l = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      w = 2'd0;
      for (int i = 0; i < 8; i++)
         if (b[l[i][0]] != 2'd0 && b[l[i][0]] == b[l[i][1]] && b[l[i][1]] == b[l[i][2]])
            w = b[l[i][0]];
      return w;
   endfunction

   // Position registers and winner detector outside the scheduler.
   logic [1:0] env_board [9];
   logic [8:0] env_occ;
   logic [1:0] env_who;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) env_board[i] <= 2'd0;
      end else begin
         for (int i = 0; i < 9; i++) begin
            if (bus.pl_en[i]) env_board[i] <= 2'd1;
            if (bus.pc_en[i]) env_board[i] <= 2'd2;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++) env_occ[i] = (env_board[i] != 2'd0);
      env_who = line_winner(env_board);
   end

   assign bus.occupied = env_occ;
   assign bus.who      = env_who;
   assign bus.win      = (env_who != 2'd0);
   assign bus.no_space = &env_occ;

   function automatic logic [21:0] hs();
      return {bus.pl_ack, bus.pl_nack, bus.pc_ack, bus.pc_nack, bus.pl_en, bus.pc_en};
   endfunction

   function automatic logic [9:0] status();
      return {busy, game_over, result, forfeit, turn, move_count};
   endfunction

   function automatic logic [9:0] exp_status();
      return {!mdone, mdone, mresult, mforfeit, mturn, 4'(mcount)};
   endfunction

   function automatic logic [17:0] env_vec();
      logic [17:0] v;
      for (int i = 0; i < 9; i++) v[2*i +: 2] = env_board[i];
      return v;
   endfunction

   function automatic logic [17:0] model_vec();
      logic [17:0] v;
      for (int i = 0; i < 9; i++) v[2*i +: 2] = mboard[i];
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bus();
      bus.pl_req = 1'b0;
      bus.pc_req = 1'b0;
      bus.pl_pos = 4'd0;
      bus.pc_pos = 4'd0;
      start      = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 9; i++) mboard[i] = 2'd0;
      mturn = 1'b0; mdone = 1'b0; mforfeit = 1'b0; mresult = 2'b00; mcount = 0; k = 0;
   endtask

   task automatic do_reset();
      idle_bus();
      #1;
      reset = 1'b1;
      #2;
      nrun++;
      if ({hs(), status()} !== 32'd0) begin
         nfail++;
         $display("FAIL reset_outputs got %h want %h", {hs(), status()}, 32'd0);
      end
      reset = 1'b0;
      model_clear();
      step();
   endtask

   task automatic start_game();
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      nrun++;
      if (status() !== exp_status()) begin
         nfail++;
         $display("FAIL start_status got %h want %h", status(), exp_status());
      end
   endtask

   // One cycle of play: optionally drive the on-turn request (and off-turn noise),
   // then compare handshakes and game status with the model's prediction.
   task automatic play_cycle(input bit drv, input logic [3:0] pos, input bit noise, input logic [3:0] npos);
      bit          legal;
      logic [8:0]  oh;
      logic [21:0] exp_hs;
      logic [1:0]  w;
      legal = 1'b0;
      if (drv && pos < 4'd9) legal = (mboard[pos] == 2'd0);
      oh = legal ? (9'd1 << pos) : 9'd0;
      if (!mturn) begin
         bus.pl_req = drv;   bus.pl_pos = pos;
         bus.pc_req = noise; bus.pc_pos = npos;
         exp_hs = {legal, drv & !legal, 2'b00, oh, 9'd0};
      end else begin
         bus.pc_req = drv;   bus.pc_pos = pos;
         bus.pl_req = noise; bus.pl_pos = npos;
         exp_hs = {2'b00, legal, drv & !legal, 9'd0, oh};
      end
      step();
      k++;
      bus.pl_req = 1'b0;
      bus.pc_req = 1'b0;
      nrun++;
      if (hs() !== exp_hs) begin
         nfail++;
         $display("FAIL handshake k=%0d pos=%0d got %h want %h", k, pos, hs(), exp_hs);
      end
      if (legal) begin
         mboard[pos] = mturn ? 2'd2 : 2'd1;
         mcount++;
         step();
         nrun++;
         if (hs() !== 22'd0) begin
            nfail++;
            $display("FAIL pulse_width got %h want %h", hs(), 22'd0);
         end
         step();
         w = line_winner(mboard);
         if (w != 2'd0) begin
            mdone = 1'b1; mresult = w;
         end else if (mcount == 9) begin
            mdone = 1'b1; mresult = 2'b11;
         end else begin
            mturn = !mturn;
         end
         k = 0;
         nrun++;
         if (env_vec() !== model_vec()) begin
            nfail++;
            $display("FAIL board got %h want %h", env_vec(), model_vec());
         end
      end else if (k == TIMEOUT) begin
         mdone = 1'b1; mforfeit = 1'b1;
         mresult = mturn ? 2'b01 : 2'b10;
      end
      nrun++;
      if (status() !== exp_status()) begin
         nfail++;
         $display("FAIL status k=%0d got %h want %h", k, status(), exp_status());
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_first_move();
      do_reset();
      start_game();
      play_cycle(1'b1, 4'd4, 1'b0, 4'd0);
      nrun++;
      if ({turn, move_count} !== {1'b1, 4'd1}) begin
         nfail++;
         $display("FAIL first_move_turn got %h want %h", {turn, move_count}, {1'b1, 4'd1});
      end
   endtask

   task automatic test_reject();
      play_cycle(1'b1, 4'd4, 1'b0, 4'd0);
      play_cycle(1'b0, 4'd0, 1'b0, 4'd0);
      play_cycle(1'b1, 4'd12, 1'b0, 4'd0);
      play_cycle(1'b0, 4'd0, 1'b0, 4'd0);
      nrun++;
      if ({busy, turn, move_count, bus.pc_en} !== {1'b1, 1'b1, 4'd1, 9'd0}) begin
         nfail++;
         $display("FAIL reject_state got %h want %h", {busy, turn, move_count, bus.pc_en}, {1'b1, 1'b1, 4'd1, 9'd0});
      end
   endtask

   task automatic test_off_turn();
      play_cycle(1'b1, 4'd0, 1'b0, 4'd0);
      bus.pc_req = 1'b1; bus.pc_pos = 4'd8;
      bus.pl_req = 1'b1; bus.pl_pos = 4'd1;
      step();
      bus.pl_req = 1'b0;
      nrun++;
      if (hs() !== {4'b1000, 9'h002, 9'h000}) begin
         nfail++;
         $display("FAIL off_turn_ack got %h want %h", hs(), {4'b1000, 9'h002, 9'h000});
      end
      step();
      nrun++;
      if (hs() !== 22'd0) begin
         nfail++;
         $display("FAIL off_turn_commit got %h want %h", hs(), 22'd0);
      end
      step();
      nrun++;
      if ({hs(), turn} !== {22'd0, 1'b1}) begin
         nfail++;
         $display("FAIL off_turn_hold got %h want %h", {hs(), turn}, {22'd0, 1'b1});
      end
      step();
      bus.pc_req = 1'b0;
      nrun++;
      if (hs() !== {4'b0010, 9'h000, 9'h100}) begin
         nfail++;
         $display("FAIL off_turn_late_ack got %h want %h", hs(), {4'b0010, 9'h000, 9'h100});
      end
      step();
      step();
      mboard[1] = 2'd1; mboard[8] = 2'd2; mcount = 4; mturn = 1'b0; k = 0;
      nrun++;
      if ({status(), env_vec()} !== {exp_status(), model_vec()}) begin
         nfail++;
         $display("FAIL off_turn_end got %h want %h", {status(), env_vec()}, {exp_status(), model_vec()});
      end
   endtask

   task automatic test_win();
      int moves [5];
      moves = '{0, 3, 1, 4, 2};
      do_reset();
      start_game();
      foreach (moves[i]) play_cycle(1'b1, 4'(moves[i]), 1'b1, 4'(moves[i]));
      nrun++;
      if ({game_over, result, move_count} !== {1'b1, 2'b01, 4'd5}) begin
         nfail++;
         $display("FAIL win_result got %h want %h", {game_over, result, move_count}, {1'b1, 2'b01, 4'd5});
      end
      for (int c = 0; c < 3; c++) begin
         start = 1'b1;
         bus.pl_req = 1'b1; bus.pl_pos = 4'd5;
         bus.pc_req = 1'b1; bus.pc_pos = 4'd6;
         step();
         nrun++;
         if ({hs(), status()} !== {22'd0, exp_status()}) begin
            nfail++;
            $display("FAIL done_ignores c=%0d got %h want %h", c, {hs(), status()}, {22'd0, exp_status()});
         end
      end
      idle_bus();
   endtask

   task automatic test_timeout();
      do_reset();
      start_game();
      repeat (TIMEOUT) play_cycle(1'b0, 4'd0, 1'b0, 4'd0);
      nrun++;
      if ({game_over, forfeit, result} !== {1'b1, 1'b1, 2'b10}) begin
         nfail++;
         $display("FAIL timeout_player got %h want %h", {game_over, forfeit, result}, {1'b1, 1'b1, 2'b10});
      end
      do_reset();
      start_game();
      repeat (TIMEOUT - 1) play_cycle(1'b0, 4'd0, 1'b0, 4'd0);
      play_cycle(1'b1, 4'd5, 1'b0, 4'd0);
      nrun++;
      if ({busy, forfeit, turn} !== {1'b1, 1'b0, 1'b1}) begin
         nfail++;
         $display("FAIL expiry_move_wins got %h want %h", {busy, forfeit, turn}, {1'b1, 1'b0, 1'b1});
      end
      repeat (TIMEOUT) play_cycle(1'b0, 4'd0, 1'b0, 4'd0);
      nrun++;
      if ({game_over, forfeit, result} !== {1'b1, 1'b1, 2'b01}) begin
         nfail++;
         $display("FAIL timeout_computer got %h want %h", {game_over, forfeit, result}, {1'b1, 1'b1, 2'b01});
      end
   endtask

   task automatic test_draw();
      int moves [9];
      moves = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      do_reset();
      start_game();
      foreach (moves[i]) play_cycle(1'b1, 4'(moves[i]), 1'b0, 4'd0);
      nrun++;
      if ({game_over, result, move_count, forfeit} !== {1'b1, 2'b11, 4'd9, 1'b0}) begin
         nfail++;
         $display("FAIL draw_result got %h want %h", {game_over, result, move_count, forfeit}, {1'b1, 2'b11, 4'd9, 1'b0});
      end
   endtask

   task automatic test_reset_in_commit();
      do_reset();
      start_game();
      bus.pl_req = 1'b1; bus.pl_pos = 4'd4;
      step();
      bus.pl_req = 1'b0;
      nrun++;
      if (bus.pl_en !== 9'h010) begin
         nfail++;
         $display("FAIL commit_en got %h want %h", bus.pl_en, 9'h010);
      end
      reset = 1'b1;
      #1;
      nrun++;
      if ({hs(), status()} !== 32'd0) begin
         nfail++;
         $display("FAIL reset_in_commit got %h want %h", {hs(), status()}, 32'd0);
      end
      #1;
      reset = 1'b0;
      model_clear();
      step();
   endtask

   task automatic test_random_games();
      bit         drv, hold, noise, legal;
      logic [3:0] pos, npos;
      int         r, s, guard;
      for (int g = 0; g < 8; g++) begin
         do_reset();
         start_game();
         hold = 1'b0;
         guard = 0;
         while (!mdone && guard < 200) begin
            drv = !hold && ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7) begin
               s = $urandom_range(0, 8);
               while (mboard[s] != 2'd0) s = (s + 1) % 9;
               pos = 4'(s);
            end else if (r < 9 || mcount == 0) begin
               pos = 4'($urandom_range(9, 15));
            end else begin
               s = $urandom_range(0, 8);
               while (mboard[s] == 2'd0) s = (s + 1) % 9;
               pos = 4'(s);
            end
            noise = ($urandom_range(0, 4) == 0);
            npos  = 4'($urandom_range(0, 15));
            legal = (pos < 4'd9) && (mboard[pos] == 2'd0);
            play_cycle(drv, pos, noise, npos);
            hold = drv && !legal;
            guard++;
         end
         nrun++;
         if (game_over !== 1'b1) begin
            nfail++;
            $display("FAIL random_game_end g=%0d got %b want %b", g, game_over, 1'b1);
         end
      end
   endtask

   initial begin
      idle_bus();
      model_clear();
      test_reset();
      test_first_move();
      test_reject();
      test_off_turn();
      test_win();
      test_timeout();
      test_draw();
      test_reset_in_commit();
      test_random_games();
      $display("[TB] %0d tests run, %0d failed", nrun, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
